// File: rtl/keypad_emulator.sv
// keypad_emulator: peripheral end of an active-low 4x4 keypad scan interface.
// Key codes arrive over a valid/ready handshake and wait in a small FIFO.
// Each key is then replayed as a timed press followed by a release gap.
// While a key is pressed, the key's column is pulled low whenever the
// scanner pulls that key's row low.
//
// Optional feature: define KEYPAD_BOUNCE_EN to model contact bounce.
// The contact then alternates closed/open during the first BOUNCE_CYCLES
// cycles of every press.
//
// pressed and done are registered, so they trail the FSM state by one
// cycle. columns is combinational from rows and the registered contact.
module keypad_emulator #(
  parameter int DEPTH         = 4,
  parameter int PRESS_CYCLES  = 16,
  parameter int GAP_CYCLES    = 8,
  parameter int BOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic       pressed,
  output logic       busy,
  output logic       done
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAXC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam int PRESS_M1 = PRESS_CYCLES - 1;
  localparam int GAP_M1   = GAP_CYCLES - 1;

  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
  localparam logic [CW-1:0] PRESS_LAST = PRESS_M1[CW-1:0];
  localparam logic [CW-1:0] GAP_LAST   = GAP_M1[CW-1:0];
  localparam logic [CW-1:0] BOUNCE_END = BOUNCE_CYCLES[CW-1:0];

`ifdef KEYPAD_BOUNCE_EN
  localparam bit BOUNCE_ON = 1'b1;
`else
  localparam bit BOUNCE_ON = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          fifo_empty;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    cur_key;
  logic          contact_next;
  logic          gap_last;
  logic [1:0]    key_row;
  logic [1:0]    key_col;

  assign key_ready  = (count != FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = key_valid && key_ready;
  assign gap_last   = (state == S_GAP) && (cnt == GAP_LAST);
  assign pop        = !fifo_empty && ((state == S_IDLE) || gap_last);
  assign busy       = (state != S_IDLE) || !fifo_empty;

  // Key storage: written on an accepted push.
  // NOTE: the storage array has no reset; the pointers and count alone
  // decide which entries are live, so resetting the data would only add logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key_code;
  end

  // FIFO pointers and occupancy; the pointers wrap naturally at DEPTH.
  // NOTE: every register here uses <= so that all state updates in one clock
  // edge see the same pre-edge values, whatever order the blocks execute in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Press/gap sequencer: the key at the FIFO head is popped into cur_key.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cur_key <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_key <= mem[rd_ptr];
            cnt     <= '0;
            state   <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (cnt == PRESS_LAST) begin
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_last) begin
            cnt <= '0;
            if (pop) begin
              cur_key <= mem[rd_ptr];
              state   <= S_PRESS;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Contact state for the next cycle.
  // With bounce enabled, the contact is open on the odd cycles of the
  // leading bounce window.
  always_comb begin
    contact_next = (state == S_PRESS) &&
                   (!BOUNCE_ON || (cnt >= BOUNCE_END) || !cnt[0]);
  end

  // Registered contact and end-of-gap pulse, both aligned one cycle after the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pressed <= 1'b0;
      done    <= 1'b0;
    end else begin
      pressed <= contact_next;
      done    <= gap_last;
    end
  end

  // Key code to keypad (row, column) position.
  always_comb begin
    // NOTE: giving both outputs a value before the case means no path leaves
    // them unassigned, so no latch is inferred.
    key_row = 2'd0;
    key_col = 2'd0;
    case (cur_key)
      4'h1: begin key_row = 2'd0; key_col = 2'd0; end
      4'h2: begin key_row = 2'd0; key_col = 2'd1; end
      4'h3: begin key_row = 2'd0; key_col = 2'd2; end
      4'hA: begin key_row = 2'd0; key_col = 2'd3; end
      4'h4: begin key_row = 2'd1; key_col = 2'd0; end
      4'h5: begin key_row = 2'd1; key_col = 2'd1; end
      4'h6: begin key_row = 2'd1; key_col = 2'd2; end
      4'hB: begin key_row = 2'd1; key_col = 2'd3; end
      4'h7: begin key_row = 2'd2; key_col = 2'd0; end
      4'h8: begin key_row = 2'd2; key_col = 2'd1; end
      4'h9: begin key_row = 2'd2; key_col = 2'd2; end
      4'hC: begin key_row = 2'd2; key_col = 2'd3; end
      4'hE: begin key_row = 2'd3; key_col = 2'd0; end
      4'h0: begin key_row = 2'd3; key_col = 2'd1; end
      4'hF: begin key_row = 2'd3; key_col = 2'd2; end
      default: begin key_row = 2'd3; key_col = 2'd3; end
    endcase
  end

  // Column return.
  // This path is zero latency, so the scanner sees the result in the same cycle.
  always_comb begin
    columns = 4'b1111;
    if (pressed && !rows[key_row]) columns[key_col] = 1'b0;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Active-low 4x4 keypad model: the peripheral end of the row/column scan interface that the keypad scanner drives.
- Accepts 4-bit key codes over a valid/ready handshake and queues them in a small FIFO.
- Replays each queued key as a timed press and release: drives columns low whenever the scanner pulls the pressed key's row low.
- Used for FPGA loopback and bench stimulus of the scanner path without a physical keypad.

Parameters:
- DEPTH, 4, key FIFO entries; power of two, >= 2.
- PRESS_CYCLES, 16, clock cycles a key is held pressed; >= 1.
- GAP_CYCLES, 8, released cycles after each press; >= 1.
- BOUNCE_CYCLES, 4, leading press cycles with contact bounce; < PRESS_CYCLES. Used only with KEYPAD_BOUNCE_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset; block is in reset while rst==0 at a rising clk edge.
- key_code  input  4  key to press; uses the key-code map below.
- key_valid  input  1  key_code is presented.
- key_ready  output  1  FIFO not full. A push occurs on an edge where key_valid && key_ready.
- rows  input  4  scanner row drive, active-low, one-hot-low while scanning.
- columns  output  4  column return, active-low, 4'b1111 when no contact.
- pressed  output  1  a key contact is currently closed (registered).
- busy  output  1  FSM not IDLE or FIFO not empty.
- done  output  1  one-cycle pulse on the last GAP cycle of each key.

Behaviour:
- Key-code map: code -> (row index r, column index c); row r active means rows[r]==0, column c returns on columns[c].
  - Row 0: 1->c0, 2->c1, 3->c2, A->c3.
  - Row 1: 4->c0, 5->c1, 6->c2, B->c3.
  - Row 2: 7->c0, 8->c1, 9->c2, C->c3.
  - Row 3: E->c0, 0->c1, F->c2, D->c3.
  - All 16 codes are valid.
- Reset (rst==0 at edge):
  - FIFO emptied; FSM forced to IDLE; counters cleared.
  - Outputs: pressed=0, done=0, busy=0, key_ready=1, columns=4'b1111.
  - Reset mid-press releases the contact immediately; the queued keys are lost.
- FIFO:
  - key_ready = (count != DEPTH), from registered count.
  - When full, pushes are ignored even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Read and write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into cur_key, clear the counter, go to PRESS.
  - PRESS: pressed=1; count up to PRESS_CYCLES-1, then clear the counter and go to GAP.
  - GAP: pressed=0; on counter==GAP_CYCLES-1, assert done for that cycle.
    - If FIFO non-empty at that point, pop and go straight to PRESS.
    - Otherwise go to IDLE.
- Timing:
  - A key pushed into an empty FIFO at edge E is popped at edge E+1; pressed=1 from E+2.
  - pressed is high for exactly PRESS_CYCLES cycles and low for at least GAP_CYCLES cycles between keys.
- columns is combinational from rows, cur_key and contact (zero latency, so the scanner samples in the same cycle):
  - columns[c] = 0 iff the contact is closed and rows[r]==0 for cur_key's (r,c); all other bits are 1.
  - rows==4'b1111 -> columns=4'b1111.
  - Multiple rows low: the pressed key's column still returns if its row is among them.
- Counter width: $clog2(max(PRESS_CYCLES,GAP_CYCLES)); it never exceeds its terminal value.

Optional Feature:
- Macro: KEYPAD_BOUNCE_EN.
- Defined: during the first BOUNCE_CYCLES cycles of PRESS, the contact alternates closed/open each cycle, starting closed at PRESS cycle 0.
  - pressed follows the contact.
  - From cycle BOUNCE_CYCLES to the end of PRESS, the contact is solidly closed.
  - Total PRESS duration is unchanged.
- Undefined: the contact is closed for all of PRESS; BOUNCE_CYCLES is ignored.

Test Plan:
- Reset: hold rst=0 for 3 cycles with key_valid=1 -> columns=4'b1111, pressed=0, busy=0, key_ready=1, no push accepted.
- Single key 5, rows swept 1110/1101/1011/0111 during PRESS:
  - columns=4'b1101 only while rows=1101; 1111 otherwise.
  - pressed high exactly 16 cycles starting 2 edges after the push.
  - done pulses once, 8 cycles after press end.
- Map check: push each of the 16 codes; during PRESS drive the expected row -> expected column low (e.g. 0: rows=0111 -> columns=1101; D: rows=0111 -> columns=0111; A: rows=1110 -> columns=0111).
- FIFO full: push 5 keys back-to-back while FSM busy -> key_ready drops after the 4th (one popped already allows a 5th only if the pop occurred); no key lost or duplicated; presses replay in push order separated by exactly 8 gap cycles.
- Reset mid-press: assert rst=0 at PRESS cycle 7 of key 3 with 2 keys queued -> next cycle columns=1111, pressed=0, busy=0; no further presses.
- With KEYPAD_BOUNCE_EN, key 8, rows=1011 held -> columns pattern 1101,1111,1101,1111, then 1101 for the remaining 12 PRESS cycles.
